// File: rtl/rng_pkg.sv
// Shared widths and thresholds for the TRNG debias/pack stage.
package rng_pkg;
  localparam int RAW_W          = 8;
  localparam int OUT_W          = 8;
  localparam int ACC_W          = 16;
  localparam int CNT_W          = 5;
  // Highest fill level at which a new raw word can still be absorbed (11 + 4 <= 15).
  localparam int ACC_ACCEPT_MAX = 11;
endpackage

// File: rtl/rng_vn_extract.sv
// Von Neumann extractor: keeps raw[2i+1] of each unequal bit-pair, compacted LSB-first.
module rng_vn_extract
  import rng_pkg::*;
(
  input  logic [RAW_W-1:0] raw_in,
  output logic [3:0]       bits,
  output logic [2:0]       k
);

  always_comb begin
    bits = '0;
    k    = '0;
    for (int i = 0; i < 4; i++) begin
      if (raw_in[2*i] != raw_in[2*i+1]) begin
        bits[k[1:0]] = raw_in[2*i+1];
        k            = k + 3'd1;
      end
    end
  end

endmodule

// File: rtl/rng_vn_packer.sv
// Debiases raw TRNG words, packs surviving bits into bytes on a valid/ready port,
// and runs a repetition-count health test that latches a sticky alarm.
module rng_vn_packer
  import rng_pkg::*;
#(
  parameter int REP_LIMIT = 8,
  parameter int RUN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RAW_W-1:0] raw_in,
  input  logic             raw_valid,
  output logic             raw_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             alarm
);

  // Handshake: a transfer happens on a posedge where valid and ready are both 1.
  // raw side never stalls the source; words offered while raw_ready=0 are dropped.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             alarm_q, alarm_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RAW_W-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;

  logic [3:0]       ext_bits;
  logic [2:0]       ext_k;
  logic             accept;
  logic             transfer;
  logic             same_word;
  logic             trip;
  logic [RUN_W-1:0] run_next;
  logic [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;

  rng_vn_extract u_extract (
    .raw_in (raw_in),
    .bits   (ext_bits),
    .k      (ext_k)
  );

  assign raw_ready = !alarm_q && (cnt_q <= CNT_W'(ACC_ACCEPT_MAX));
  assign accept    = raw_valid && raw_ready;
  assign transfer  = (cnt_q >= CNT_W'(OUT_W)) && (!out_valid_q || out_ready);
  assign same_word = prev_valid_q && (raw_in == prev_q);
  assign run_next  = same_word ? run_q + RUN_W'(1) : RUN_W'(1);
  assign trip      = accept && (run_next == RUN_W'(REP_LIMIT));

  // Bits from a same-edge accept land above whatever survives the outgoing byte.
  assign base_acc  = transfer ? (acc_q >> OUT_W) : acc_q;
  assign base_cnt  = transfer ? (cnt_q - CNT_W'(OUT_W)) : cnt_q;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    alarm_d      = alarm_q;
    run_d        = run_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;

    if (accept) begin
      run_d        = run_next;
      prev_d       = raw_in;
      prev_valid_d = 1'b1;
    end

    if (trip) begin
      alarm_d     = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      acc_d = base_acc;
      cnt_d = base_cnt;
      if (transfer) begin
        out_data_d  = acc_q[OUT_W-1:0];
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        acc_d = base_acc | (ACC_W'(ext_bits) << base_cnt);
        cnt_d = base_cnt + CNT_W'(ext_k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      alarm_q      <= 1'b0;
      run_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      alarm_q      <= alarm_d;
      run_q        <= run_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign alarm     = alarm_q;

endmodule

// File: doc/rng_vn_packer.md
Name: rng_vn_packer

Overview:
- Downstream stage of the ring-oscillator TRNG array. Consumes the registered 8-bit raw XOR word each clk.
- Applies von Neumann debiasing to the 4 bit-pairs of each word and packs the surviving bits into bytes.
- Presents each byte on a valid/ready interface.
- Runs a repetition-count health test on raw words; a failure raises a sticky alarm.

Parameters:
- REP_LIMIT, 8: consecutive identical accepted raw words that trip the alarm (range 2..255).
- RUN_W, 8: width of the run-length counter; must satisfy 2**RUN_W > REP_LIMIT.

Ports:
- clk  in  1  single clock, posedge
- rst  in  1  reset, synchronous, active-high
- raw_in  in  8  raw entropy word
- raw_valid  in  1  raw_in valid (tie high for free-running source)
- raw_ready  out  1  block accepts raw_in this cycle
- out_data  out  8  debiased byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- alarm  out  1  sticky health-test failure

Behaviour:
- Reset (rst=1 at posedge): the following clear to 0: acc, cnt, out_data, out_valid, alarm, run counter, prev-word valid. raw_ready is then 1.
- Accept condition: raw_valid & raw_ready at posedge. If raw_ready=0, raw_in is dropped; the upstream block never stalls.
- raw_ready = !alarm && (cnt <= 11). It is combinational from registers only.
- Extraction: pair i (i=0..3) = {raw_in[2i+1], raw_in[2i]}.
  - Pair 01 yields bit 0; pair 10 yields bit 1. In both cases the yielded bit is raw_in[2i+1].
  - Pairs 00 and 11 are discarded.
  - A word yields k = 0..4 bits, in pair order 0..3.
- Packing: 16-bit accumulator acc with 5-bit count cnt (max 15).
  - New bits are written at acc[cnt], acc[cnt+1], ... The first extracted bit lands at the lowest free position.
- Transfer: at a posedge where cnt >= 8 and (!out_valid || out_ready):
  - out_data <= acc[7:0]; out_valid <= 1.
  - acc shifts right by 8; cnt -= 8.
  - A transfer and an accept may occur on the same edge. In that case the new bits land at position cnt-8 and the new count is cnt - 8 + k.
- Output handshake:
  - out_valid & out_ready at a posedge with no transfer on that edge: out_valid <= 0.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Latency: a byte completed by an accept at edge N is visible with out_valid=1 after edge N+1, provided the output register is free.
- Health test (repetition count):
  - The first accepted word after reset sets run=1.
  - Each later accepted word equal to the previous accepted word increments run. Any different word sets run=1.
  - When run would reach REP_LIMIT:
    - alarm <= 1 on that edge.
    - The triggering word's bits are discarded.
    - acc, cnt and out_valid clear to 0; the held byte is lost.
  - While alarm=1: raw_ready=0 and out_valid stays 0. Only rst clears alarm.
- Reset mid-operation: all partial bits and any held byte are discarded. There is no flush.
- Simultaneous rst and any event: rst wins.

Decomposition:
- Shared package rng_pkg:
  - RAW_W=8, OUT_W=8, ACC_W=16, CNT_W=5.
  - ACC_ACCEPT_MAX=11 (ready threshold).
- One sub-module: rng_vn_extract. Purely combinational; maps raw_in[7:0] to {bits[3:0] compacted LSB-first, k[2:0]}.
- Packer, handshake and health test stay in rng_vn_packer.

Test Plan:
- Basic pack: after rst, out_ready=1, feed 0x99 then 0x66 one per cycle. Expect out_valid=1 one edge after the 2nd accept, out_data=0x5A, and cnt returns to 0.
- No entropy: alternate 0x00/0xFF for 50 cycles. Expect out_valid never 1, raw_ready stays 1, alarm=0.
- Backpressure: out_ready=0, feed 0x99,0x66,0x99,0x66,0x99,0x66 alternately.
  - Expect out_data=0x5A held.
  - raw_ready drops after cnt reaches 12; words offered while raw_ready=0 are dropped.
  - Raise out_ready: bytes 0x5A then 0x5A drain on consecutive transfers, and raw_ready returns to 1.
- Health alarm: feed 0x99 for REP_LIMIT=8 consecutive accepts.
  - Expect bytes 0xAA emitted for the first words.
  - On the 8th accept: alarm=1, out_valid=0, raw_ready=0, persisting 20 cycles.
  - Assert rst: all outputs return to 0, raw_ready returns to 1.
- Boundary run: feed 0x99 ×7, 0x66, 0x99 ×7. Expect alarm stays 0 (run resets on 0x66).
- Mid-operation reset: feed 0x99 (cnt=4), assert rst 1 cycle, then feed 0x66, 0x99. Expect first byte 0xA5 (bits 1,0,1,0,0,1,0,1), not the stale bits.
